// File: rtl/hazard_control_unit_if.sv
// Hazard unit bus: decoder/pipeline hazard inputs, PC and pipeline-register controls, perf counters.
interface hazard_control_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_Jump;
  logic             EX_MemRead;
  logic [4:0]       EX_Rt;
  logic             EX_BranchTaken;
  logic             MEM_MemRead;
  logic             MEM_MemWrite;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             EX_MEM_Write;
  logic             MEM_WB_Flush;
  logic             mem_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output ID_Rs, ID_Rt, ID_Jump, EX_MemRead, EX_Rt, EX_BranchTaken, MEM_MemRead, MEM_MemWrite,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush,
           mem_busy, stall_cycles, flush_events
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_Jump, EX_MemRead, EX_Rt, EX_BranchTaken, MEM_MemRead, MEM_MemWrite,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush,
           mem_busy, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: load-use stalls, branch/jump flushes, multi-cycle memory freeze, perf counters.
// The interface CNT_W must match this module's CNT_W.
module hazard_control_unit #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_control_unit_if.slave  bus
);
  localparam int unsigned    CW       = 4;
  localparam logic [CW-1:0]  CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             access, luse, freeze;
  logic             rule_branch, rule_luse, rule_jump;
  logic             stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Freeze sequencing, then hazard priority: freeze > branch > load-use > jump.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    freeze     = 1'b0;
    access     = bus.MEM_MemRead | bus.MEM_MemWrite;
    luse       = bus.EX_MemRead && (bus.EX_Rt != 5'd0) &&
                 ((bus.EX_Rt == bus.ID_Rs) || (bus.EX_Rt == bus.ID_Rt));
    case (state)
      ST_RUN: begin
        if (access && (WAIT_CYCLES > 0)) begin
          freeze     = 1'b1;
          cnt_next   = CNT_INIT;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt != '0) begin
          freeze   = 1'b1;
          cnt_next = cnt - CW'(1);
        end else begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
    if (reset) begin
      freeze     = 1'b0;
      state_next = ST_RUN;
      cnt_next   = '0;
    end
    rule_branch = !reset && !freeze && bus.EX_BranchTaken;
    rule_luse   = !reset && !freeze && !bus.EX_BranchTaken && luse;
    rule_jump   = !reset && !freeze && !bus.EX_BranchTaken && !luse && bus.ID_Jump;
    stall_inc   = freeze | rule_luse;
    flush_inc   = rule_branch | rule_jump;
  end

  assign bus.PC_Write     = !(freeze || rule_luse);
  assign bus.IF_ID_Write  = !(freeze || rule_luse);
  assign bus.EX_MEM_Write = !freeze;
  assign bus.MEM_WB_Flush = freeze;
  assign bus.IF_ID_Flush  = rule_branch | rule_jump;
  assign bus.ID_EX_Flush  = rule_branch | rule_luse;
  assign bus.mem_busy     = !reset && (state == ST_WAIT);

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;
endmodule
